// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the issue-side hazard scoreboard: register ids,
// forward-select encoding and the per-stage write tag.
package cpu_types_pkg;

  localparam int REG_W      = 5;
  localparam int TAG_STAGES = 3;   // EX, MEM, WB
  localparam int NUM_SRC    = 2;   // rs, rt

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     load;
  } scb_entry_t;

  function automatic logic tag_hit(input scb_entry_t e, input regbits_t r);
    return e.valid && (e.wsel == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Port bundle for hazard_scoreboard; hs is the block's view, tb the driver's view.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic nRST
);
  logic                      ihit, dmemreq_M, dhit;
  cpu_types_pkg::regbits_t   rs_ID, rt_ID, wsel_ID;
  logic                      use_rs_ID, use_rt_ID, wen_ID, load_ID;
  logic                      halt_WB, mispredict_M;
  logic                      en_IFID, en_IDEX, en_EXM, en_MWB;
  logic                      flush_IFID, flush_IDEX;
  cpu_types_pkg::fwd_sel_t   fwd_A_EX, fwd_B_EX;
  logic                      halted;
  logic [CNT_W-1:0]          stall_cnt, flush_cnt;

  modport hs (
    input  CLK, nRST, ihit, dmemreq_M, dhit, rs_ID, rt_ID, use_rs_ID, use_rt_ID,
           wsel_ID, wen_ID, load_ID, halt_WB, mispredict_M,
    output en_IFID, en_IDEX, en_EXM, en_MWB, flush_IFID, flush_IDEX,
           fwd_A_EX, fwd_B_EX, halted, stall_cnt, flush_cnt
  );

  modport tb (
    input  CLK, nRST, en_IFID, en_IDEX, en_EXM, en_MWB, flush_IFID, flush_IDEX,
           fwd_A_EX, fwd_B_EX, halted, stall_cnt, flush_cnt,
    output ihit, dmemreq_M, dhit, rs_ID, rt_ID, use_rs_ID, use_rt_ID,
           wsel_ID, wen_ID, load_ID, halt_WB, mispredict_M
  );
endinterface

// File: rtl/scb_match.sv
// One decode source operand checked against the EX and MEM write tags:
// produces its forward select and whether it hits a load sitting in EX.
module scb_match
  import cpu_types_pkg::*;
(
  input  regbits_t   src,
  input  logic       use_src,
  input  scb_entry_t ex,
  input  logic       mem_valid,
  input  regbits_t   mem_wsel,
  output fwd_sel_t   sel,
  output logic       lu_hit
);

  // EX is checked first: it holds the youngest write, which is in MEM by
  // the time this operand is consumed in EX.
  always_comb begin
    sel = FWD_REG;
    if (use_src && (src != '0)) begin
      if (tag_hit(ex, src))
        sel = FWD_MEM;
      else if (mem_valid && (mem_wsel == src))
        sel = FWD_WB;
    end
  end

  assign lu_hit = use_src && ex.load && tag_hit(ex, src);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard controller: tracks in-flight writes in EX/MEM/WB, stalls
// on load-use, flushes on mispredict and registers forward selects into EX.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dmemreq_M,
  input  logic             dhit,
  input  regbits_t         rs_ID,
  input  regbits_t         rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  regbits_t         wsel_ID,
  input  logic             wen_ID,
  input  logic             load_ID,
  input  logic             halt_WB,
  input  logic             mispredict_M,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXM,
  output logic             en_MWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output fwd_sel_t         fwd_A_EX,
  output fwd_sel_t         fwd_B_EX,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  scb_entry_t                tag_q [TAG_STAGES];  // [0]=EX [1]=MEM [2]=WB
  scb_entry_t                id_entry;
  regbits_t   [NUM_SRC-1:0]  src;
  logic       [NUM_SRC-1:0]  use_src;
  logic       [NUM_SRC-1:0]  lu_src;
  fwd_sel_t   [NUM_SRC-1:0]  sel;
  logic                      advance, lu, bubble;

  assign src     = {rt_ID, rs_ID};
  assign use_src = {use_rt_ID, use_rs_ID};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    scb_match u_match (
      .src       (src[i]),
      .use_src   (use_src[i]),
      .ex        (tag_q[0]),
      .mem_valid (tag_q[1].valid),
      .mem_wsel  (tag_q[1].wsel),
      .sel       (sel[i]),
      .lu_hit    (lu_src[i])
    );
  end

  assign advance = ihit && (!dmemreq_M || dhit) && !halted;
  assign lu      = |lu_src;
  // A mispredict squashes the decode slot, so it also resolves any load-use.
  assign bubble  = lu || mispredict_M;

  assign en_IFID    = advance && (!lu || mispredict_M);
  assign en_IDEX    = advance;
  assign en_EXM     = advance;
  assign en_MWB     = advance;
  assign flush_IFID = advance && mispredict_M;
  assign flush_IDEX = advance && bubble;

  always_comb begin
    id_entry       = '0;
    id_entry.valid = wen_ID && (wsel_ID != '0);
    id_entry.wsel  = wsel_ID;
    id_entry.load  = load_ID;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < TAG_STAGES; i++) tag_q[i] <= '0;
      fwd_A_EX <= FWD_REG;
      fwd_B_EX <= FWD_REG;
    end else if (advance) begin
      tag_q[0] <= bubble ? '0 : id_entry;
      for (int i = 1; i < TAG_STAGES; i++) tag_q[i] <= tag_q[i-1];
      fwd_A_EX <= bubble ? FWD_REG : sel[0];
      fwd_B_EX <= bubble ? FWD_REG : sel[1];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) halted <= 1'b0;
    else       halted <= halted || halt_WB;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (advance) begin
      if (lu && !mispredict_M && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (mispredict_M && (flush_cnt != '1))        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard against a queue-based
// model of the in-flight instruction history.
module tb_hazard_scoreboard;
  import cpu_types_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  hazard_scoreboard_if #(.CNT_W(CNT_W)) hif (.CLK(CLK), .nRST(nRST));

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(hif.ihit), .dmemreq_M(hif.dmemreq_M), .dhit(hif.dhit),
    .rs_ID(hif.rs_ID), .rt_ID(hif.rt_ID),
    .use_rs_ID(hif.use_rs_ID), .use_rt_ID(hif.use_rt_ID),
    .wsel_ID(hif.wsel_ID), .wen_ID(hif.wen_ID), .load_ID(hif.load_ID),
    .halt_WB(hif.halt_WB), .mispredict_M(hif.mispredict_M),
    .en_IFID(hif.en_IFID), .en_IDEX(hif.en_IDEX), .en_EXM(hif.en_EXM), .en_MWB(hif.en_MWB),
    .flush_IFID(hif.flush_IFID), .flush_IDEX(hif.flush_IDEX),
    .fwd_A_EX(hif.fwd_A_EX), .fwd_B_EX(hif.fwd_B_EX),
    .halted(hif.halted), .stall_cnt(hif.stall_cnt), .flush_cnt(hif.flush_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist holds the three most recent issue slots, youngest first: [0] is the
  // instruction now in EX, [1] in MEM, [2] in WB. Bubbles are invalid records.
  typedef struct { bit v; int dst; bit ld; } rec_t;
  rec_t hist[$];
  bit   m_halted;
  int   m_fa, m_fb, m_stall, m_flush;

  task automatic model_reset();
    rec_t z;
    z.v = 0; z.dst = 0; z.ld = 0;
    hist = {};
    repeat (3) hist.push_back(z);
    m_halted = 0; m_fa = 0; m_fb = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic int exp_sel(input int r, input bit u);
    if (!u || r == 0) return 0;
    if (hist[0].v && hist[0].dst == r) return 1;
    if (hist[1].v && hist[1].dst == r) return 2;
    return 0;
  endfunction

  initial begin
    bit   adv, lu, mp, n_halted;
    int   n_fa, n_fb, n_stall, n_flush;
    rec_t nr;
    model_reset();
    forever begin
      @(negedge CLK);
      if (!nRST) model_reset();
      mp  = hif.mispredict_M;
      adv = hif.ihit && (!hif.dmemreq_M || hif.dhit) && !m_halted;
      lu  = hist[0].v && hist[0].ld &&
            ((hif.use_rs_ID && int'(hif.rs_ID) == hist[0].dst) ||
             (hif.use_rt_ID && int'(hif.rt_ID) == hist[0].dst));
      chk("en_IFID",    hif.en_IFID,    32'(adv && (!lu || mp)));
      chk("en_IDEX",    hif.en_IDEX,    32'(adv));
      chk("en_EXM",     hif.en_EXM,     32'(adv));
      chk("en_MWB",     hif.en_MWB,     32'(adv));
      chk("flush_IFID", hif.flush_IFID, 32'(adv && mp));
      chk("flush_IDEX", hif.flush_IDEX, 32'(adv && (lu || mp)));
      chk("fwd_A_EX",   hif.fwd_A_EX,   m_fa);
      chk("fwd_B_EX",   hif.fwd_B_EX,   m_fb);
      chk("halted",     hif.halted,     32'(m_halted));
      chk("stall_cnt",  hif.stall_cnt,  m_stall);
      chk("flush_cnt",  hif.flush_cnt,  m_flush);
      n_fa = m_fa; n_fb = m_fb; n_stall = m_stall; n_flush = m_flush;
      nr.v = 0; nr.dst = 0; nr.ld = 0;
      if (adv) begin
        if (!(lu || mp)) begin
          nr.v  = hif.wen_ID && (hif.wsel_ID != 0);
          nr.dst = int'(hif.wsel_ID);
          nr.ld = hif.load_ID;
          n_fa = exp_sel(int'(hif.rs_ID), hif.use_rs_ID);
          n_fb = exp_sel(int'(hif.rt_ID), hif.use_rt_ID);
        end else begin
          n_fa = 0; n_fb = 0;
        end
        if (lu && !mp && n_stall < CNT_MAX) n_stall++;
        if (mp && n_flush < CNT_MAX) n_flush++;
      end
      n_halted = m_halted || hif.halt_WB;
      @(posedge CLK);
      if (!nRST) model_reset();
      else begin
        if (adv) begin
          hist.push_front(nr);
          void'(hist.pop_back());
        end
        m_fa = n_fa; m_fb = n_fb; m_stall = n_stall; m_flush = n_flush;
        m_halted = n_halted;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_id(input int rs, input bit urs, input int rt, input bit urt,
                        input int wsel, input bit wen, input bit ld);
    hif.rs_ID = regbits_t'(rs);  hif.use_rs_ID = urs;
    hif.rt_ID = regbits_t'(rt);  hif.use_rt_ID = urt;
    hif.wsel_ID = regbits_t'(wsel); hif.wen_ID = wen; hif.load_ID = ld;
  endtask

  task automatic set_mem(input bit ih, input bit dreq, input bit dh, input bit mp, input bit hw);
    hif.ihit = ih; hif.dmemreq_M = dreq; hif.dhit = dh; hif.mispredict_M = mp; hif.halt_WB = hw;
  endtask

  task automatic set_idle();
    set_mem(0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a rising edge; asserts reset mid-cycle, releases it
  // mid-cycle, and returns just after the following rising edge.
  task automatic do_reset();
    #2 nRST = 1'b0;
    @(negedge CLK);
    #2 nRST = 1'b1;
    tick();
  endtask

  initial begin
    set_idle();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    tick();
    chk("rst_fwdA", hif.fwd_A_EX, 0);
    chk("rst_stall", hif.stall_cnt, 0);

    // back-to-back ALU: add $3 ; sub uses $3
    set_idle(); do_reset();
    set_mem(1, 0, 0, 0, 0); set_id(1, 1, 2, 1, 3, 1, 0); tick();
    set_id(3, 1, 5, 1, 6, 1, 0); #1;
    chk("alu_en_IFID", hif.en_IFID, 1);
    chk("alu_flush_IDEX", hif.flush_IDEX, 0);
    tick();
    chk("alu_fwdA", hif.fwd_A_EX, 1);
    chk("alu_fwdB", hif.fwd_B_EX, 0);
    set_idle(); tick();
    chk("alu_stall_cnt", hif.stall_cnt, 0);

    // lw $4 ; add uses $4 as rt
    set_idle(); do_reset();
    set_mem(1, 0, 0, 0, 0); set_id(0, 0, 0, 0, 4, 1, 1); tick();
    set_id(1, 1, 4, 1, 7, 1, 0); #1;
    chk("lu_en_IFID", hif.en_IFID, 0);
    chk("lu_flush_IDEX", hif.flush_IDEX, 1);
    chk("lu_en_EXM", hif.en_EXM, 1);
    tick();
    chk("lu_bubble_fwdB", hif.fwd_B_EX, 0);
    chk("lu_clear_en_IFID", hif.en_IFID, 1);
    chk("lu_clear_flush", hif.flush_IDEX, 0);
    tick();
    chk("lu_fwdB", hif.fwd_B_EX, 2);
    chk("lu_stall_cnt", hif.stall_cnt, 1);

    // lw $4 ; add uses $4 with mispredict in the same cycle
    set_idle(); do_reset();
    set_mem(1, 0, 0, 0, 0); set_id(0, 0, 0, 0, 4, 1, 1); tick();
    set_mem(1, 0, 0, 1, 0); set_id(1, 1, 4, 1, 7, 1, 0); #1;
    chk("mp_flush_IFID", hif.flush_IFID, 1);
    chk("mp_flush_IDEX", hif.flush_IDEX, 1);
    chk("mp_en_IFID", hif.en_IFID, 1);
    tick(); set_idle(); #1;
    chk("mp_flush_cnt", hif.flush_cnt, 1);
    chk("mp_stall_cnt", hif.stall_cnt, 0);
    chk("mp_fwdB", hif.fwd_B_EX, 0);

    // lw $4 ; add uses $4 during a 3-cycle memory wait
    set_idle(); do_reset();
    set_mem(1, 0, 0, 0, 0); set_id(0, 0, 0, 0, 4, 1, 1); tick();
    set_mem(1, 1, 0, 0, 0); set_id(1, 1, 4, 1, 7, 1, 0);
    repeat (3) begin
      #1;
      chk("wait_en_IFID", hif.en_IFID, 0);
      chk("wait_en_IDEX", hif.en_IDEX, 0);
      chk("wait_en_MWB", hif.en_MWB, 0);
      chk("wait_flush_IDEX", hif.flush_IDEX, 0);
      tick();
    end
    chk("wait_stall_cnt", hif.stall_cnt, 0);
    set_mem(1, 1, 1, 0, 0); #1;
    chk("wait_lu_en_IFID", hif.en_IFID, 0);
    chk("wait_lu_flush", hif.flush_IDEX, 1);
    tick(); #1;
    chk("wait_after_en_IFID", hif.en_IFID, 1);
    chk("wait_after_flush", hif.flush_IDEX, 0);
    tick();
    chk("wait_stall_once", hif.stall_cnt, 1);
    chk("wait_fwdB", hif.fwd_B_EX, 2);

    // randomized traffic with occasional mid-run resets
    set_idle(); do_reset();
    for (int c = 0; c < 4000; c++) begin
      set_mem($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 8, 0);
      set_id($urandom_range(0, 3), $urandom_range(0, 99) < 80,
             $urandom_range(0, 3), $urandom_range(0, 99) < 80,
             $urandom_range(0, 3), $urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < 35);
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
    end

    // $0 never forwards or stalls; then halt freezes; then async reset
    set_idle(); do_reset();
    set_mem(1, 0, 0, 0, 0); set_id(0, 0, 0, 0, 0, 1, 1); tick();
    set_id(0, 1, 0, 1, 8, 1, 0); #1;
    chk("r0_en_IFID", hif.en_IFID, 1);
    chk("r0_flush_IDEX", hif.flush_IDEX, 0);
    tick();
    chk("r0_fwdA", hif.fwd_A_EX, 0);
    chk("r0_fwdB", hif.fwd_B_EX, 0);
    set_id(0, 0, 0, 0, 5, 1, 1); tick();
    set_id(5, 1, 0, 0, 9, 1, 0); tick();
    set_mem(1, 0, 0, 1, 0); tick();
    set_mem(1, 0, 0, 0, 1); set_id(0, 0, 0, 0, 0, 0, 0); tick();
    set_mem(1, 0, 0, 1, 0); set_id(5, 1, 5, 1, 9, 1, 0); #1;
    chk("halt_halted", hif.halted, 1);
    chk("halt_en_IFID", hif.en_IFID, 0);
    chk("halt_en_IDEX", hif.en_IDEX, 0);
    chk("halt_flush_IFID", hif.flush_IFID, 0);
    repeat (3) tick();
    chk("halt_stall_cnt", hif.stall_cnt, 1);
    chk("halt_flush_cnt", hif.flush_cnt, 1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_halted", hif.halted, 0);
    chk("arst_stall_cnt", hif.stall_cnt, 0);
    chk("arst_flush_cnt", hif.flush_cnt, 0);
    chk("arst_fwdA", hif.fwd_A_EX, 0);
    chk("arst_en_IDEX", hif.en_IDEX, 1);
    chk("arst_flush_IFID", hif.flush_IFID, 1);
    @(negedge CLK);
    #2 nRST = 1'b1;
    tick();
    set_idle(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side hazard controller for the five-stage pipeline. It tracks in-flight register writes by stage, detects load-use hazards at decode, and issues the pipeline-latch enable/flush controls. It precomputes operand forwarding selects at decode and registers them into EX, so the datapath forwarding muxes read a registered select instead of a late comparator chain. It sits beside the ID stage and drives the IF/ID, ID/EX, EX/MEM and MEM/WB latch controls.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush performance counters

Ports:
- CLK  in  1  pipeline clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dmemreq_M  in  1  MEM-stage instruction is accessing data memory
- dhit  in  1  data access complete this cycle
- rs_ID, rt_ID  in  regbits_t  decode source registers
- use_rs_ID, use_rt_ID  in  1  decode instruction actually reads rs / rt
- wsel_ID  in  regbits_t  decode destination register
- wen_ID  in  1  decode instruction writes the register file
- load_ID  in  1  decode instruction is a load
- halt_WB  in  1  HALT has reached writeback
- mispredict_M  in  1  branch resolved in MEM differs from the prediction
- en_IFID, en_IDEX, en_EXM, en_MWB  out  1  latch enables
- flush_IFID, flush_IDEX  out  1  latch clears; they insert a bubble
- fwd_A_EX, fwd_B_EX  out  2  registered forward selects: 00 register file, 01 MEM result, 10 WB result
- halted  out  1  sticky halt
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Tag pipeline: three registered entries, EX, MEM and WB. Each entry holds {valid, wsel, load}. On advance, ID shifts into EX, EX into MEM, MEM into WB, and the old WB entry is dropped.
- An entry shifted in from ID is valid only if wen_ID=1 and wsel_ID≠0.
- advance = ihit && (!dmemreq_M || dhit) && !halted.
- Load-use: lu = EX.valid && EX.load && ((use_rs_ID && rs_ID==EX.wsel) || (use_rt_ID && rt_ID==EX.wsel)).
- During an lu cycle:
  - en_IFID=0, so IF/ID holds.
  - flush_IDEX=1, so the EX tag is loaded invalid and both fwd selects are loaded as 00.
  - EX/MEM and MEM/WB advance normally.
  - lu clears on the next cycle because the load has moved to MEM. A single load therefore stalls for exactly one advancing cycle.
- Forward select for rs, computed combinationally at ID:
  - 01 if EX.valid && rs_ID==EX.wsel; this entry becomes MEM when the instruction reaches EX.
  - else 10 if MEM.valid && rs_ID==MEM.wsel.
  - else 00.
  - The rt select uses the same rules. A select is forced to 00 when the operand is unused or the register is $0. When EX and MEM both match, EX wins.
- fwd_*_EX load on advance; otherwise they hold.
- mispredict_M=1 with advance: flush_IFID=1 and flush_IDEX=1. The EX tag is loaded invalid and the selects are loaded as 00. Flush takes priority over lu, so en_IFID=1 even if lu is true.
- en_IDEX, en_EXM and en_MWB equal advance. en_IFID = advance && (!lu || mispredict_M).
- halt_WB=1 sets halted. halted stays set until reset, forces advance=0, and freezes all latches and counters.
- stall_cnt increments on each advancing cycle with lu && !mispredict_M. flush_cnt increments on each advancing cycle with mispredict_M. Both saturate at all ones.

## Timing
- Reset values: all tag entries invalid, fwd_A_EX=fwd_B_EX=00, halted=0, counters=0.
- Reset is asynchronous. Asserting it mid-stall or mid-flush clears all state immediately.
- While nRST is low, the outputs read as follows, since all tags are invalid:
  - en_* = ihit && (!dmemreq_M || dhit).
  - flush_* = 0 unless mispredict_M is asserted.
- Enables and flushes are combinational from current inputs and state, with no added latency.
- fwd_*_EX are valid one cycle after decode, on the same edge the instruction enters EX.
- A non-advancing cycle (memory wait) changes no state. lu and mispredict_M are re-evaluated on the cycle that advances.

## Structure
- fwd_sel_t is a 2-bit enum: FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
- scb_entry_t is a struct {valid, wsel, load}.
- Both typedefs go in cpu_types_pkg. All ports are bundled in hazard_scoreboard_if.vh, with modports hs for the block and tb for the bench.
- One sub-module: scb_match. It compares one source register against the EX and MEM entries and returns fwd_sel_t. It is instantiated twice, once for rs and once for rt.

## Test plan
- Back-to-back ALU ops: add $3 followed by sub using $3. Required: fwd_A_EX=01 in the sub's EX cycle, no stall, stall_cnt=0.
- lw $4 followed by add using $4 as rt. Required: one cycle with en_IFID=0 and flush_IDEX=1, then fwd_B_EX=10, stall_cnt=1.
- lw $4 while mispredict_M=1 in the same cycle. Required: flush_IFID=flush_IDEX=1, en_IFID=1, flush_cnt=1, stall_cnt=0.
- lw $4 then an add using $4, with dmemreq_M=1 and dhit=0 for 3 cycles. Required: all enables 0 for 3 cycles and state frozen; the stall bubble is then inserted exactly once.
- Writes to $0 followed by a use of $0. Required: fwd selects 00 and no lu. After halt_WB pulses, halted=1, en_*=0 and the counters hold. Asserting nRST low mid-run clears all outputs to their reset values.
